fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: LEN, 32, datapath width of PC and instruction.
REQ-002 Parameter: RESET_PC, 0, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit stall; the same signal drives the downstream IF/ID register's stall.
REQ-006 redirect  input  1  branch/jump taken this cycle.
REQ-007 redirect_pc  input  LEN  target PC, valid when redirect=1.
REQ-008 imem_req  output  1  one-cycle instruction-memory request strobe.
REQ-009 imem_addr  output  LEN  fetch address, valid when imem_req=1.
REQ-010 imem_ack  input  1  one-cycle response strobe, at least 1 cycle after imem_req.
REQ-011 imem_rdata  input  LEN  instruction word, valid when imem_ack=1.
REQ-012 next_inced_pc  output  LEN  PC+4 of the presented instruction, 0 when none; feeds IF/ID.
REQ-013 next_instruction  output  LEN  presented instruction, 0 (NOP) when none; feeds IF/ID.
REQ-014 fetch_valid  output  1  1 when next_instruction holds a real fetched instruction.

Function
REQ-015 State: registers pc[LEN], buf[LEN], FSM state in {IDLE, WAIT, HOLD, DISCARD}; at most one memory request outstanding.
REQ-016 imem_req SHALL be 1 exactly when state=IDLE, redirect=0 and reset=0; imem_addr SHALL equal pc at all times.
REQ-017 IDLE: redirect=1 -> pc<=redirect_pc, stay IDLE; else issue request, go WAIT; stall does not block requests.
REQ-018 WAIT, redirect=1, imem_ack=0 -> pc<=redirect_pc, go DISCARD.
REQ-019 WAIT, redirect=1, imem_ack=1 -> drop imem_rdata, pc<=redirect_pc, go IDLE, fetch_valid=0.
REQ-020 WAIT, redirect=0, imem_ack=1, stall=0 -> present imem_rdata same cycle (combinational), fetch_valid=1, next_inced_pc=pc+4; pc<=pc+4; go IDLE.
REQ-021 WAIT, redirect=0, imem_ack=1, stall=1 -> buf<=imem_rdata, go HOLD, fetch_valid=0 this cycle.
REQ-022 WAIT, imem_ack=0, redirect=0 -> stay WAIT, fetch_valid=0.
REQ-023 HOLD: present buf, fetch_valid=1, next_inced_pc=pc+4 every cycle; stall=0 and redirect=0 -> pc<=pc+4, go IDLE; stall=1 -> stay HOLD, pc unchanged.
REQ-024 HOLD, redirect=1 -> discard buf, pc<=redirect_pc, go IDLE; redirect has priority over stall.
REQ-025 DISCARD: outputs invalid; imem_ack=1 -> drop data, go IDLE; redirect=1 -> pc<=redirect_pc (may coincide with ack); stay DISCARD until ack.
REQ-026 When fetch_valid=0, next_instruction and next_inced_pc SHALL be 0.
REQ-027 PC arithmetic modulo 2^LEN; pc+4 wraps (0xFFFFFFFC -> 0x00000000) without error.
REQ-028 imem_ack in IDLE or HOLD is a protocol violation; ignored, no state change.
REQ-029 Steady-state throughput: one instruction per 2 cycles with 1-cycle memory latency.

Reset
REQ-030 reset=1 SHALL set pc=RESET_PC, buf=0, state=IDLE, and force imem_req=0, fetch_valid=0, next_instruction=0, next_inced_pc=0 in that cycle, overriding all other inputs.
REQ-031 Reset mid-request (WAIT/DISCARD) SHALL abandon the request; a late imem_ack after reset is ignored per REQ-028 only if it arrives while state=IDLE, else consumed as a normal ack.
REQ-032 First imem_req SHALL occur the cycle after reset deasserts, with imem_addr=RESET_PC.

Verification
REQ-033 Reset, 1-cycle memory returning 0x20080005 at addr 0 -> req at 0 in cycle 1, fetch_valid=1, next_instruction=0x20080005, next_inced_pc=4 in cycle 2, next req at addr 4 in cycle 3.
REQ-034 Ack with stall=1 held 3 cycles, data 0x8C090000 at addr 8 -> HOLD, outputs 0x8C090000 / 12 held until stall drops, then pc=12 and req at 12.
REQ-035 redirect to 0x40 while WAIT at addr 4, ack 2 cycles later -> that data never presented, next req at 0x40.
REQ-036 redirect to 0x80 in same cycle as ack at addr 0x10 -> fetch_valid=0 that cycle, next cycle req at 0x80.
REQ-037 RESET_PC=0xFFFFFFFC, fetch word 0x00000000 -> next_inced_pc=0, next req at 0x00000000.
REQ-038 reset asserted during WAIT -> all outputs 0 that cycle, req at RESET_PC the cycle after deassert.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction-memory request/response bus.
//   imem_req   : one-cycle request strobe (fetch unit -> memory)
//   imem_addr  : fetch address, valid with imem_req (fetch unit -> memory)
//   imem_ack   : one-cycle response strobe (memory -> fetch unit)
//   imem_rdata : instruction word, valid with imem_ack (memory -> fetch unit)
// master: fetch side. slave: memory side.
interface fetch_unit_if #(
    parameter int unsigned LEN = 32
);
    logic           imem_req;
    logic [LEN-1:0] imem_addr;
    logic           imem_ack;
    logic [LEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding-request instruction fetch stage.
// Issues one request per fetch, presents the returned word to IF/ID either
// combinationally on the ack cycle or from a hold buffer while stalled, and
// drops in-flight or buffered words on a redirect.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   stall               : hazard stall (shared with IF/ID register)
//   redirect/redirect_pc: taken branch/jump and its target
//   imem                : instruction-memory bus (master side)
//   next_inced_pc       : PC+4 of presented instruction, 0 when none
//   next_instruction    : presented instruction, 0 when none
//   fetch_valid         : next_instruction holds a real fetched word
module fetch_unit #(
    parameter int unsigned    LEN      = 32,
    parameter logic [LEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           redirect,
    input  logic [LEN-1:0] redirect_pc,
    fetch_unit_if.master   imem,
    output logic [LEN-1:0] next_inced_pc,
    output logic [LEN-1:0] next_instruction,
    output logic           fetch_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD,
        ST_DISCARD
    } state_t;

    state_t         state_q, state_d;
    logic [LEN-1:0] pc_q, pc_d;
    logic [LEN-1:0] buf_q, buf_d;
    logic [LEN-1:0] pc_inc;

    // Wraps modulo 2^LEN by construction.
    assign pc_inc = pc_q + LEN'(4);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        unique case (state_q)
            ST_IDLE: begin
                // A stray ack here is ignored; only redirect matters.
                if (redirect) pc_d = redirect_pc;
                else          state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = imem.imem_ack ? ST_IDLE : ST_DISCARD;
                end else if (imem.imem_ack) begin
                    if (stall) begin
                        buf_d   = imem.imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // Redirect wins over stall and drops the buffered word.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ST_IDLE;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (redirect)       pc_d    = redirect_pc;
                if (imem.imem_ack)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem.imem_req    = 1'b0;
        imem.imem_addr   = pc_q;
        fetch_valid      = 1'b0;
        next_instruction = '0;
        next_inced_pc    = '0;
        if (!reset) begin
            unique case (state_q)
                ST_IDLE: imem.imem_req = !redirect;
                ST_WAIT: begin
                    // Ack passes straight through to IF/ID when nothing blocks it.
                    if (imem.imem_ack && !redirect && !stall) begin
                        fetch_valid      = 1'b1;
                        next_instruction = imem.imem_rdata;
                        next_inced_pc    = pc_inc;
                    end
                end
                ST_HOLD: begin
                    if (!redirect) begin
                        fetch_valid      = 1'b1;
                        next_instruction = buf_q;
                        next_inced_pc    = pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ins;
        logic [31:0] e_inc;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: RESET_PC = 0
    logic        reset0 = 1'b1, stall0 = 1'b0, redirect0 = 1'b0;
    logic [31:0] redirect_pc0 = '0;
    logic [31:0] inc0, ins0;
    logic        vld0;
    fetch_unit_if #(.LEN(32)) bus0 ();

    fetch_unit #(.LEN(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk              (clk),
        .reset            (reset0),
        .stall            (stall0),
        .redirect         (redirect0),
        .redirect_pc      (redirect_pc0),
        .imem             (bus0),
        .next_inced_pc    (inc0),
        .next_instruction (ins0),
        .fetch_valid      (vld0)
    );

    // DUT 1: RESET_PC at top of address space
    logic        reset1 = 1'b1, stall1 = 1'b0, redirect1 = 1'b0;
    logic [31:0] redirect_pc1 = '0;
    logic [31:0] inc1, ins1;
    logic        vld1;
    fetch_unit_if #(.LEN(32)) bus1 ();

    fetch_unit #(.LEN(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk              (clk),
        .reset            (reset1),
        .stall            (stall1),
        .redirect         (redirect1),
        .redirect_pc      (redirect_pc1),
        .imem             (bus1),
        .next_inced_pc    (inc1),
        .next_instruction (ins1),
        .fetch_valid      (vld1)
    );

    int total = 0;
    int bad   = 0;
    vec_t vecs[31];

    function automatic vec_t mk(logic rst, logic stl, logic rdr, logic [31:0] rpc,
                                logic ack, logic [31:0] rdata, logic e_req,
                                logic [31:0] e_addr, logic e_vld, logic [31:0] e_ins,
                                logic [31:0] e_inc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_ins = e_ins; v.e_inc = e_inc;
        return v;
    endfunction

    task automatic check1(string name, logic req, logic [31:0] addr, logic vld,
                          logic [31:0] ins, logic [31:0] inc, logic e_req,
                          logic [31:0] e_addr, logic e_vld, logic [31:0] e_ins,
                          logic [31:0] e_inc);
        total++;
        if (req !== e_req || addr !== e_addr || vld !== e_vld || ins !== e_ins || inc !== e_inc) begin
            bad++;
            $display("FAIL %s: got req=%b addr=%h vld=%b ins=%h inc=%h, want req=%b addr=%h vld=%b ins=%h inc=%h",
                     name, req, addr, vld, ins, inc, e_req, e_addr, e_vld, e_ins, e_inc);
        end
    endtask

    initial begin
        //                rst stl rdr rpc           ack rdata          req addr          vld ins            inc
        vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 0, 32'h0,        1, 32'h2008_0005,0, 32'h0000_0000, 1, 32'h2008_0005, 32'h4);
        vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 0, 32'h0,        32'h0);
        vecs[4]  = mk(0, 0, 0, 32'h0,        1, 32'h1111_1111,0, 32'h0000_0004, 1, 32'h1111_1111, 32'h8);
        vecs[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 32'h0,        32'h0);
        // ack under stall -> HOLD, held for three stalled cycles
        vecs[6]  = mk(0, 1, 0, 32'h0,        1, 32'h8C09_0000,0, 32'h0000_0008, 0, 32'h0,        32'h0);
        vecs[7]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0008, 1, 32'h8C09_0000, 32'hC);
        vecs[8]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0008, 1, 32'h8C09_0000, 32'hC);
        vecs[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0008, 1, 32'h8C09_0000, 32'hC);
        vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_000C, 0, 32'h0,        32'h0);
        vecs[11] = mk(0, 0, 0, 32'h0,        1, 32'hAAAA_0001,0, 32'h0000_000C, 1, 32'hAAAA_0001, 32'h10);
        vecs[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0010, 0, 32'h0,        32'h0);
        // redirect during WAIT, ack two cycles later is dropped
        vecs[13] = mk(0, 0, 1, 32'h40,       0, 32'h0,        0, 32'h0000_0010, 0, 32'h0,        32'h0);
        vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0040, 0, 32'h0,        32'h0);
        vecs[15] = mk(0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF,0, 32'h0000_0040, 0, 32'h0,        32'h0);
        vecs[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0040, 0, 32'h0,        32'h0);
        vecs[17] = mk(0, 0, 0, 32'h0,        1, 32'h1234_5678,0, 32'h0000_0040, 1, 32'h1234_5678, 32'h44);
        // redirect in IDLE suppresses the request
        vecs[18] = mk(0, 0, 1, 32'h10,       0, 32'h0,        0, 32'h0000_0044, 0, 32'h0,        32'h0);
        vecs[19] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0010, 0, 32'h0,        32'h0);
        // redirect coincident with ack
        vecs[20] = mk(0, 0, 1, 32'h80,       1, 32'hCAFE_F00D,0, 32'h0000_0010, 0, 32'h0,        32'h0);
        vecs[21] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0080, 0, 32'h0,        32'h0);
        vecs[22] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0080, 0, 32'h0,        32'h0);
        // reset while WAIT, with an ack that same cycle
        vecs[23] = mk(1, 0, 0, 32'h0,        1, 32'h5555_5555,0, 32'h0000_0080, 0, 32'h0,        32'h0);
        // late ack in IDLE is ignored; request goes out at RESET_PC
        vecs[24] = mk(0, 0, 0, 32'h0,        1, 32'h6666_6666,1, 32'h0000_0000, 0, 32'h0,        32'h0);
        vecs[25] = mk(0, 0, 0, 32'h0,        1, 32'h7777_7777,0, 32'h0000_0000, 1, 32'h7777_7777, 32'h4);
        vecs[26] = mk(0, 0, 0, 32'h0,        1, 32'h9999_9999,1, 32'h0000_0004, 0, 32'h0,        32'h0);
        vecs[27] = mk(0, 1, 0, 32'h0,        1, 32'h0BAD_C0DE,0, 32'h0000_0004, 0, 32'h0,        32'h0);
        // stray ack in HOLD changes nothing
        vecs[28] = mk(0, 1, 0, 32'h0,        1, 32'h3333_3333,0, 32'h0000_0004, 1, 32'h0BAD_C0DE, 32'h8);
        vecs[29] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0004, 1, 32'h0BAD_C0DE, 32'h8);
        vecs[30] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 32'h0,        32'h0);

        bus0.imem_ack = 1'b0; bus0.imem_rdata = '0;
        bus1.imem_ack = 1'b0; bus1.imem_rdata = '0;
        @(posedge clk);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            reset0 = vecs[i].rst;  stall0 = vecs[i].stl;
            redirect0 = vecs[i].rdr; redirect_pc0 = vecs[i].rpc;
            bus0.imem_ack = vecs[i].ack; bus0.imem_rdata = vecs[i].rdata;
            #2;
            check1($sformatf("vec%0d", i), bus0.imem_req, bus0.imem_addr, vld0, ins0, inc0,
                   vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_ins, vecs[i].e_inc);
        end

        // PC wrap at top of address space (second instance)
        @(negedge clk);
        reset1 = 1'b1; bus1.imem_ack = 1'b0;
        #2;
        check1("wrap_reset", bus1.imem_req, bus1.imem_addr, vld1, ins1, inc1,
               1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset1 = 1'b0;
        #2;
        check1("wrap_req", bus1.imem_req, bus1.imem_addr, vld1, ins1, inc1,
               1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        bus1.imem_ack = 1'b1; bus1.imem_rdata = 32'h0000_0000;
        #2;
        check1("wrap_ack", bus1.imem_req, bus1.imem_addr, vld1, ins1, inc1,
               1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        bus1.imem_ack = 1'b0;
        #2;
        check1("wrap_next", bus1.imem_req, bus1.imem_addr, vld1, ins1, inc1,
               1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
